// File: rtl/imem_port_arbiter_pkg.sv
// rtl/imem_port_arbiter_pkg.sv - shared sizes and FSM state encoding for the instruction memory port arbiter
package imem_pkg;

    localparam int IMEM_ADDR_W = 14;
    localparam int IMEM_DEPTH  = 16384;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RESTART = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and instruction RAM signals of the port arbiter
interface imem_port_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) ();

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_stall;
    logic              f_valid;
    logic [DATA_W-1:0] f_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_done;
    logic              ld_ack;
    logic              ld_err;
    logic              cpu_hold;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
        output f_stall, f_valid, f_rdata, ld_ack, ld_err, cpu_hold,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
        input  f_stall, f_valid, f_rdata, ld_ack, ld_err, cpu_hold,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the instruction RAM between fetch and UART loader; IMEM_LOAD_CNT_EN adds ld_cnt
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
`ifdef IMEM_LOAD_CNT_EN
    output logic [ADDR_W:0] ld_cnt,
`endif
    imem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_DRAIN   = DRAIN;
    localparam logic [1:0] S_LOAD    = LOAD;
    localparam logic [1:0] S_RESTART = RESTART;

    // One bit wider than the address so DEPTH itself is representable.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              f_valid_q;
    logic              ld_ack_q;
    logic              ld_err_q;
    logic              ld_in_range;
    logic              fetch_go;
    logic              ld_take;
    logic              ld_write;
    logic              load_entry;
    logic              mem_en_c;
    logic              mem_we_c;
    logic              f_stall_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign ld_in_range = {1'b0, bus.ld_addr} < DEPTH_W;

    // Decide who owns the RAM port this cycle; a loader request always blocks a new fetch.
    always_comb begin
        fetch_go    = (state == S_RUN) && bus.f_req && !bus.ld_req;
        ld_take     = (state == S_LOAD) && bus.ld_req;
        ld_write    = ld_take && ld_in_range;
        mem_en_c    = fetch_go || ld_write;
        mem_we_c    = ld_write;
        f_stall_c   = (state != S_RUN) || bus.ld_req;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (state == S_RUN) begin
            mem_addr_c = bus.f_addr;
        end else if (state == S_LOAD) begin
            mem_addr_c  = bus.ld_addr;
            mem_wdata_c = bus.ld_wdata;
        end
    end

    // Next state: drain a read issued last cycle before handing the port to the loader.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:     if (bus.ld_req) state_nxt = f_valid_q ? S_DRAIN : S_LOAD;
            S_DRAIN:   state_nxt = S_LOAD;
            S_LOAD:    if (bus.ld_done) state_nxt = S_RESTART;
            S_RESTART: state_nxt = S_RUN;
            default:   state_nxt = S_RUN;
        endcase
        load_entry = (state != S_LOAD) && (state_nxt == S_LOAD);
    end

    // FSM, fetch data valid, loader acknowledge and sticky range error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            f_valid_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            f_valid_q <= fetch_go;
            ld_ack_q  <= ld_take;
            if (load_entry) begin
                ld_err_q <= 1'b0;
            end else if (ld_take && !ld_in_range) begin
                ld_err_q <= 1'b1;
            end
        end
    end

`ifdef IMEM_LOAD_CNT_EN
    // Count words actually written by the most recent load, saturating at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt <= '0;
        end else if (load_entry) begin
            ld_cnt <= '0;
        end else if (ld_write && (ld_cnt != DEPTH_W)) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end
`endif

    // RAM-side outputs are forced low while reset is held so no write can land mid-abort.
    assign bus.mem_en    = rst & mem_en_c;
    assign bus.mem_we    = rst & mem_we_c;
    assign bus.mem_addr  = rst ? mem_addr_c : '0;
    assign bus.mem_wdata = rst ? mem_wdata_c : '0;
    assign bus.f_stall   = rst & f_stall_c;
    assign bus.f_valid   = f_valid_q;
    assign bus.f_rdata   = f_valid_q ? bus.mem_rdata : '0;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.ld_err    = ld_err_q;
    assign bus.cpu_hold  = (state != S_RUN);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter with a behavioural model
module tb_imem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 12000;

    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_LOAD    = 2;
    localparam int M_RESTART = 3;

    typedef struct { int cyc; logic [31:0] data; } fetch_t;
    typedef struct { int cyc; logic [13:0] addr; logic [31:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef IMEM_LOAD_CNT_EN
    logic [ADDR_W:0] ld_cnt;
`endif

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
`ifdef IMEM_LOAD_CNT_EN
        .ld_cnt (ld_cnt),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [0:16383];

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0: return 32'h00000013;
            1: return 32'h00100093;
            2: return 32'h00208113;
            default: return 32'h5A000000 ^ (32'(i) * 32'h9E3779B1);
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    logic [31:0] ref_mem [int];
    fetch_t exp_fetch [$];
    wr_t    exp_wr [$];
    int     exp_ack [$];
    int     m_mode = M_RUN;
    bit     m_fetched = 0;
    bit     m_err = 0;
    int     m_cnt = 0;
    bit     m_consumed = 0;
    bit     e_hold = 0;
    bit     e_stall = 0;
    bit     e_err = 0;
`ifdef IMEM_LOAD_CNT_EN
    int     e_cnt = 0;
`endif

    bit          v_freq, v_lreq, v_ldone;
    logic [13:0] v_faddr, v_laddr;
    logic [31:0] v_lwd;

    function automatic logic [31:0] ref_rd(input logic [13:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(int'(a));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        int nxt;
        fetch_t f;
        wr_t w;
        m_consumed = 0;
        e_hold  = (m_mode != M_RUN);
        e_stall = (m_mode != M_RUN) || v_lreq;
        e_err   = m_err;
`ifdef IMEM_LOAD_CNT_EN
        e_cnt   = m_cnt;
`endif
        nxt = m_mode;
        if (m_mode == M_RUN) begin
            if (v_lreq) begin
                nxt = m_fetched ? M_DRAIN : M_LOAD;
                m_fetched = 0;
            end else begin
                if (v_freq) begin
                    f.cyc = cyc + 1;
                    f.data = ref_rd(v_faddr);
                    exp_fetch.push_back(f);
                end
                m_fetched = v_freq;
            end
        end else if (m_mode == M_DRAIN) begin
            nxt = M_LOAD;
            m_fetched = 0;
        end else if (m_mode == M_LOAD) begin
            m_fetched = 0;
            if (v_lreq) begin
                m_consumed = 1;
                exp_ack.push_back(cyc + 1);
                if (int'(v_laddr) < DEPTH) begin
                    w.cyc = cyc; w.addr = v_laddr; w.data = v_lwd;
                    exp_wr.push_back(w);
                    ref_mem[int'(v_laddr)] = v_lwd;
                    if (m_cnt < DEPTH) m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (v_ldone) nxt = M_RESTART;
        end else begin
            nxt = M_RUN;
            m_fetched = 0;
        end
        if (nxt == M_LOAD && m_mode != M_LOAD) begin
            m_err = 0;
            m_cnt = 0;
        end
        m_mode = nxt;
    endtask

    task automatic model_reset();
        exp_fetch.delete();
        exp_wr.delete();
        exp_ack.delete();
        m_mode = M_RUN; m_fetched = 0; m_err = 0; m_cnt = 0;
        e_hold = 0; e_stall = 0; e_err = 0;
`ifdef IMEM_LOAD_CNT_EN
        e_cnt = 0;
`endif
    endtask

    task automatic cycle_drive(input bit freq, input logic [13:0] faddr, input bit lreq,
                               input logic [13:0] laddr, input logic [31:0] lwd, input bit ldone);
        @(posedge clk);
        #1;
        v_freq = freq; v_faddr = faddr; v_lreq = lreq; v_laddr = laddr; v_lwd = lwd; v_ldone = ldone;
        bus.f_req = freq; bus.f_addr = faddr; bus.ld_req = lreq;
        bus.ld_addr = laddr; bus.ld_wdata = lwd; bus.ld_done = ldone;
        model_eval();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_drive(0, '0, 0, '0, '0, 0);
    endtask

    task automatic ld_word(input logic [13:0] a, input logic [31:0] d, input bit done, input bit freq);
        int n;
        n = 0;
        do begin
            cycle_drive(freq, 14'($urandom_range(0, 63)), 1, a, d, done);
            n++;
        end while (!m_consumed && n < 20);
        if (!m_consumed) begin
            checks++; errors++;
            $display("FAIL ld_word_timeout addr=%h", a);
        end
    endtask

    task automatic fetch_expect(input logic [13:0] a, input logic [31:0] want);
        cycle_drive(1, a, 0, '0, '0, 0);
        cycle_drive(0, '0, 0, '0, '0, 0);
        @(negedge clk);
        chk("direct_f_valid", bus.f_valid, 1);
        chk("direct_f_rdata", bus.f_rdata, want);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_f_stall"}, bus.f_stall, 0);
        chk({tag, "_f_valid"}, bus.f_valid, 0);
        chk({tag, "_f_rdata"}, bus.f_rdata, 0);
        chk({tag, "_ld_ack"}, bus.ld_ack, 0);
        chk({tag, "_ld_err"}, bus.ld_err, 0);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, 0);
`ifdef IMEM_LOAD_CNT_EN
        chk({tag, "_ld_cnt"}, ld_cnt, 0);
`endif
    endtask

    // Monitor: per-cycle status plus queue-driven checks of fetch data, acks and writes.
    always @(negedge clk) begin
        if (rst) begin
            chk("cpu_hold", bus.cpu_hold, e_hold);
            chk("f_stall", bus.f_stall, e_stall);
            chk("ld_err", bus.ld_err, e_err);
`ifdef IMEM_LOAD_CNT_EN
            chk("ld_cnt", ld_cnt, e_cnt);
`endif
            if (exp_fetch.size() > 0 && exp_fetch[0].cyc == cyc) begin
                chk("f_valid", bus.f_valid, 1);
                chk("f_rdata", bus.f_rdata, exp_fetch[0].data);
                void'(exp_fetch.pop_front());
            end else begin
                chk("f_valid", bus.f_valid, 0);
            end
            if (exp_ack.size() > 0 && exp_ack[0] == cyc) begin
                chk("ld_ack", bus.ld_ack, 1);
                void'(exp_ack.pop_front());
            end else begin
                chk("ld_ack", bus.ld_ack, 0);
            end
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                chk("mem_we", bus.mem_we, 1);
                chk("mem_en", bus.mem_en, 1);
                chk("mem_addr", bus.mem_addr, exp_wr[0].addr);
                chk("mem_wdata", bus.mem_wdata, exp_wr[0].data);
                void'(exp_wr.pop_front());
            end else begin
                chk("mem_we", bus.mem_we, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int nw;
        logic [13:0] a;
        for (int i = 0; i < 16384; i++) ram[i] = init_word(i);
        bus.f_req = 0; bus.f_addr = '0; bus.ld_req = 0; bus.ld_addr = '0;
        bus.ld_wdata = '0; bus.ld_done = 0; bus.mem_rdata = '0;
        v_freq = 0; v_faddr = '0; v_lreq = 0; v_laddr = '0; v_lwd = '0; v_ldone = 0;
        #2;
        check_all_zero("reset");
        #20;
        rst = 1'b1;

        // Plain fetch stream
        idle(1);
        cycle_drive(1, 14'd0, 0, '0, '0, 0);
        cycle_drive(1, 14'd1, 0, '0, '0, 0);
        cycle_drive(1, 14'd2, 0, '0, '0, 0);
        idle(2);

        // Collision with a read in flight, then 3-word load and a separate ld_done
        cycle_drive(1, 14'd3, 0, '0, '0, 0);
        ld_word(14'd0, 32'hDEADBEEF, 0, 1);
        ld_word(14'd1, 32'h12345678, 0, 0);
        ld_word(14'd2, 32'hCAFEF00D, 0, 0);
`ifdef IMEM_LOAD_CNT_EN
        @(negedge clk);
        chk("ld_cnt_after_3", ld_cnt, 3);
`endif
        cycle_drive(0, '0, 0, '0, '0, 1);
        idle(2);
        fetch_expect(14'd0, 32'hDEADBEEF);
        fetch_expect(14'd2, 32'hCAFEF00D);

        // Out-of-range word, then a new load clears ld_err; last word coincident with ld_done
        ld_word(14'(DEPTH), 32'h0BAD0BAD, 0, 0);
        ld_word(14'd5, 32'h55555555, 0, 0);
        cycle_drive(0, '0, 0, '0, '0, 1);
        idle(3);
        ld_word(14'd6, 32'h66666666, 0, 0);
        ld_word(14'd7, 32'h77777777, 1, 0);
        idle(2);
        fetch_expect(14'd7, 32'h77777777);

        // Randomised mix of fetch runs and loads
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < int'($urandom_range(3, 16)); k++)
                cycle_drive(1'($urandom_range(0, 1)), 14'($urandom_range(0, 63)), 0, '0, '0, 0);
            nw = $urandom_range(1, 5);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 3) == 0)
                    cycle_drive(1'($urandom_range(0, 1)), 14'($urandom_range(0, 63)), 0, '0, '0, 0);
                if ($urandom_range(0, 9) == 0) a = 14'(DEPTH + $urandom_range(0, 16383 - DEPTH));
                else a = 14'($urandom_range(0, 63));
                ld_word(a, $urandom, (k == nw - 1) && ($urandom_range(0, 1) == 1),
                        1'($urandom_range(0, 1)));
            end
            if (!(m_mode == M_RESTART)) cycle_drive(0, '0, 0, '0, '0, 1);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(3);

        // Asynchronous reset between two loader writes
        ld_word(14'd100, 32'hA5A50001, 0, 0);
        @(posedge clk);
        #1;
        bus.ld_addr = 14'd101; bus.ld_wdata = 32'hA5A50002; bus.f_req = 1;
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_mem_we", bus.mem_we, 0);
            chk("abort_mem_en", bus.mem_en, 0);
        end
        bus.f_req = 0; bus.ld_req = 0; bus.ld_done = 0;
        v_freq = 0; v_lreq = 0; v_ldone = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(1);
        fetch_expect(14'd100, 32'hA5A50001);
        fetch_expect(14'd101, init_word(101));
        idle(4);

        chk("fetch_queue_empty", exp_fetch.size(), 0);
        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("write_queue_empty", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
